// File: rtl/led_fader_if.sv
// Chaser-to-fader bus: on/off LED pattern and brightness in, PWM LED drive out.
interface led_fader_if #(
  parameter int unsigned NUM_LEDS = 16,
  parameter int unsigned PWM_BITS = 8
);
  logic [NUM_LEDS-1:0] led_in;
  logic [PWM_BITS-1:0] max_level;
  logic [NUM_LEDS-1:0] LED;

  modport master (output led_in, output max_level, input LED);
  modport slave  (input led_in, input max_level, output LED);
endinterface

// File: rtl/led_fader.sv
// Per-channel PWM afterglow: a lit channel shows max_level, a dropped channel
// fades out by DECAY_STEP on every prescaler tick, saturating at zero.
module led_fader #(
  parameter int unsigned NUM_LEDS     = 16,
  parameter int unsigned PWM_BITS     = 8,
  parameter int unsigned DECAY_CYCLES = 390625,
  parameter int unsigned DECAY_STEP   = 16
) (
  input logic        clk,
  input logic        rst,
  led_fader_if.slave bus
);
  localparam int unsigned         PRE_W    = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(DECAY_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] STEP     = PWM_BITS'(DECAY_STEP);

  logic [NUM_LEDS-1:0] in_q;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
  logic [PWM_BITS-1:0] level_q [NUM_LEDS];
  logic [PWM_BITS-1:0] level_d [NUM_LEDS];
  logic                tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q      <= '0;
      led_q     <= '0;
      pwm_cnt_q <= '0;
      pre_cnt_q <= '0;
      for (int unsigned i = 0; i < NUM_LEDS; i++) level_q[i] <= '0;
    end else begin
      in_q      <= bus.led_in;
      led_q     <= led_d;
      pwm_cnt_q <= pwm_cnt_d;
      pre_cnt_q <= pre_cnt_d;
      for (int unsigned i = 0; i < NUM_LEDS; i++) level_q[i] <= level_d[i];
    end
  end

  // Load beats decay: a held channel is reloaded even on a tick cycle.
  always_comb begin
    tick      = (pre_cnt_q == PRE_LAST);
    pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    led_d     = '0;
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      led_d[i] = (level_q[i] > pwm_cnt_q);
      if (in_q[i])
        level_d[i] = bus.max_level;
      else if (tick)
        level_d[i] = (level_q[i] >= STEP) ? level_q[i] - STEP : '0;
      else
        level_d[i] = level_q[i];
    end
  end

  assign bus.LED = led_q;
endmodule

// File: tb/tb_led_fader.sv
// Directed and random checks of led_fader against a cycle-count based model.
module tb_led_fader;
  localparam int NL = 16, PB = 4, DC = 4, DS = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  led_fader_if #(.NUM_LEDS(NL), .PWM_BITS(PB)) bus ();

  led_fader #(.NUM_LEDS(NL), .PWM_BITS(PB), .DECAY_CYCLES(DC), .DECAY_STEP(DS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference: time measured in edges since reset release; pwm phase and tick
  // follow from that count, levels are plain integers with saturating decay.
  int unsigned cyc;
  logic [NL-1:0] m_in, m_led;
  int m_lvl [NL];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc = 0; m_in = '0; m_led = '0;
      for (int i = 0; i < NL; i++) m_lvl[i] = 0;
    end else begin
      for (int i = 0; i < NL; i++) m_led[i] = (m_lvl[i] > int'(cyc % 16));
      for (int i = 0; i < NL; i++) begin
        if (m_in[i]) m_lvl[i] = int'(bus.max_level);
        else if ((cyc % DC) == DC - 1) m_lvl[i] = (m_lvl[i] >= DS) ? m_lvl[i] - DS : 0;
      end
      m_in = bus.led_in;
      cyc++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    chk("led_vs_model", 32'(bus.LED), 32'(m_led));
    for (int i = 0; i < NL; i++) chk("level_vs_model", 32'(dut.level_q[i]), 32'(m_lvl[i]));
  endtask

  task automatic decay_seq(input int ch, input int lvl, input string tag);
    int vals[$];
    int when[$];
    int prev;
    bus.max_level = 4'(lvl);
    bus.led_in = 16'(1) << ch;
    repeat (3) step();
    chk({tag, "_loaded"}, 32'(dut.level_q[ch]), 32'(lvl));
    bus.led_in = '0;
    prev = lvl;
    vals.push_back(lvl);
    for (int k = 0; k < 40 && prev != 0; k++) begin
      step();
      if (int'(dut.level_q[ch]) != prev) begin
        prev = int'(dut.level_q[ch]);
        vals.push_back(prev);
        when.push_back(int'(cyc));
      end
    end
    chk({tag, "_nsteps"}, 32'(vals.size()), 32'((lvl + DS - 1) / DS + 1));
    for (int k = 0; k < vals.size(); k++)
      chk({tag, "_value"}, 32'(vals[k]), 32'((lvl - k * DS) > 0 ? lvl - k * DS : 0));
    for (int k = 1; k < when.size(); k++)
      chk({tag, "_spacing"}, 32'(when[k] - when[k-1]), 32'(DC));
  endtask

  initial begin
    int ones, lit;
    bus.led_in = '0;
    bus.max_level = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_led", 32'(bus.LED), 32'h0);

    // random traffic
    for (int k = 0; k < 120; k++) begin
      bus.led_in = 16'($urandom & $urandom & $urandom);
      bus.max_level = 4'($urandom_range(0, 15));
      step();
    end

    // asynchronous reset mid-operation with everything lit
    bus.led_in = 16'hFFFF;
    bus.max_level = 4'd15;
    repeat (5) step();
    #2 rst = 1'b1;
    #1 chk("async_reset_led", 32'(bus.LED), 32'h0);
    for (int i = 0; i < NL; i++) chk("async_reset_level", 32'(dut.level_q[i]), 32'h0);
    repeat (2) @(negedge clk);
    chk("held_reset_led", 32'(bus.LED), 32'h0);
    rst = 1'b0;
    step(); chk("rise_e0", 32'(bus.LED[0]), 32'h0);
    step(); chk("rise_e1", 32'(bus.LED[0]), 32'h0);
    step(); chk("rise_e2", 32'(bus.LED[0]), 32'h1);
    ones = 0;
    for (int k = 0; k < 16; k++) begin step(); ones += int'(bus.LED[0]); end
    chk("full_duty", 32'(ones), 32'd15);

    // duty at level 6 on channel 3
    bus.led_in = 16'h0008;
    bus.max_level = 4'd6;
    repeat (4) step();
    ones = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      chk("duty_phase", 32'(bus.LED[3]), 32'(((cyc - 1) % 16) < 6));
      ones += int'(bus.LED[3]);
    end
    chk("duty_count", 32'(ones), 32'd6);

    // max_level 0 with input held: dark
    bus.led_in = 16'h0080;
    bus.max_level = 4'd0;
    repeat (3) step();
    ones = 0;
    for (int k = 0; k < 16; k++) begin step(); ones += int'(bus.LED[7]); end
    chk("zero_level_dark", 32'(ones), 32'd0);

    decay_seq(5, 15, "decay");
    step();
    ones = 0;
    for (int k = 0; k < 16; k++) begin step(); ones += int'(bus.LED[5]); end
    chk("decay_off", 32'(ones), 32'd0);
    decay_seq(5, 7, "saturate");

    // priority: load beats tick, reload follows max_level
    bus.led_in = 16'h0004;
    bus.max_level = 4'd15;
    repeat (2) step();
    for (int k = 0; k < 10; k++) begin step(); chk("priority_hold", 32'(dut.level_q[2]), 32'd15); end
    bus.max_level = 4'd3;
    step(); step();
    chk("priority_reload", 32'(dut.level_q[2]), 32'd3);

    // walking one, then let everything fade out
    bus.max_level = 4'd15;
    for (int ch = 0; ch < NL; ch++) begin
      bus.led_in = 16'(1) << ch;
      for (int k = 0; k < 8; k++) begin
        step();
        lit = 0;
        for (int i = 0; i < NL; i++) lit += (dut.level_q[i] != 0) ? 1 : 0;
        chk("trail_len", 32'(lit <= 4), 32'h1);
      end
    end
    bus.led_in = '0;
    repeat (24) step();
    for (int i = 0; i < NL; i++) chk("trail_dark", 32'(dut.level_q[i]), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/led_fader.md
# led_fader

Per-channel PWM afterglow stage that sits directly downstream of the 16-bit LED chaser. It consumes the chaser's one-hot/on-off LED vector and drives the board LED pins. A lit input channel is shown at a programmable brightness. When the input drops, the channel fades out in fixed steps, producing a comet-tail trail behind the moving LED.

## Interface
- `NUM_LEDS`, 16, number of channels.
- `PWM_BITS`, 8, width of the PWM counter and of each per-channel brightness level.
- `DECAY_CYCLES`, 390625, clock cycles per decay tick (3.90625 ms at 100 MHz, so a full 255→0 fade with step 16 takes ≈62.5 ms); must be ≥1.
- `DECAY_STEP`, 16, amount subtracted from a level on each decay tick; 1 ≤ `DECAY_STEP` ≤ 2^PWM_BITS−1.

Ports:
- `clk`  input  1  system clock (100 MHz on board).
- `rst`  input  1  reset: asynchronous, active-high.
- `led_in`  input  NUM_LEDS  on/off pattern from the chaser, synchronous to `clk`.
- `max_level`  input  PWM_BITS  brightness loaded into a channel while its input is high; quasi-static.
- `LED`  output  NUM_LEDS  PWM-modulated drive to the LED pins, registered.

## Operation
Registered state:
- `in_q[NUM_LEDS]`: `led_in` registered once.
- `pwm_cnt[PWM_BITS]`: free-running counter, +1 every cycle, wraps 2^PWM_BITS−1 → 0.
- `pre_cnt`: prescaler of width $clog2(DECAY_CYCLES), minimum 1 bit. Counts 0..DECAY_CYCLES−1, then wraps to 0.
  - `tick` is high for exactly the one cycle in which `pre_cnt == DECAY_CYCLES−1`.
  - With DECAY_CYCLES=1, `tick` is high every cycle.
- `level[i][PWM_BITS]` per channel.
- `LED` output register.

Per-channel level update, evaluated each cycle in priority order:
1. `in_q[i]==1`: `level[i] <= max_level`. The level is reloaded every cycle, so it tracks `max_level` changes while the channel is held; a reload can raise or lower the level.
2. Otherwise, if `tick`: `level[i] <= (level[i] >= DECAY_STEP) ? level[i]−DECAY_STEP : 0`. Saturating subtraction; the level never wraps.
3. Otherwise: hold.

Output rules:
- `LED[i] <= (level[i] > pwm_cnt)`, unsigned compare using current-cycle register values.
  - Duty cycle is exactly level/2^PWM_BITS.
  - Level 0 is always off.
  - Level 2^PWM_BITS−1 is on for all but one cycle per PWM period.
- All channels share one `pwm_cnt` and one `tick`.
- There is no per-channel timing state beyond `level`.

Boundary conditions:
- `tick` and `in_q[i]` high in the same cycle: load wins, no decay.
- `max_level==0` with input held: channel dark.
- Input pulse of one cycle: the full `max_level` is loaded, then decay begins at the next `tick`. The first decrement can come 1..DECAY_CYCLES cycles after the input drops, because the prescaler is free-running and never restarted by input activity.
- Multiple channels high simultaneously: each channel is independent.
- `rst` asserted at any time, including mid-fade: all state clears immediately, with no glitch-free requirement on `LED` during reset.

## Timing
- Reset values: `in_q`=0, `pwm_cnt`=0, `pre_cnt`=0, every `level`=0, `LED`=0.
- First `tick` occurs in the DECAY_CYCLES-th cycle after reset release, when `pre_cnt` first equals DECAY_CYCLES−1.
- Latency from `led_in[i]` rising (sampled at edge N):
  - `in_q` set at N.
  - `level` = `max_level` at N+1.
  - `LED[i]` can first assert at N+2, if `max_level > pwm_cnt` at that time.
- Latency from `led_in[i]` falling: `level` holds until the first `tick` cycle after `in_q` clears, then steps down once per `tick`.
- Number of ticks to dark from level L: ceil(L/DECAY_STEP).
- PWM period: 2^PWM_BITS cycles (2.56 µs at 100 MHz with defaults).
- No handshakes; `led_in` is consumed every cycle.

## Test plan
Bench uses PWM_BITS=4, DECAY_CYCLES=4, DECAY_STEP=5, NUM_LEDS=16.

- **Reset:** assert `rst` mid-operation, `led_in`=16'hFFFF, `max_level`=15 → `LED`=0 and all levels 0 during reset. After release, `LED[0]` first rises 2 cycles after the first sampled edge, and is high 15 of every 16 cycles.
- **Duty:** hold `led_in[3]`=1, `max_level`=6 → `LED[3]` high exactly 6 of every 16 consecutive cycles, in the cycles after `pwm_cnt` values 0..5.
- **Decay:** load 15 on ch 5, then drop input → level sequence 15, 10, 5, 0 on successive ticks (4 cycles apart); `LED[5]` fully off after the 3rd tick; level never wraps.
- **Saturation:** `max_level`=7, release → levels 7, 2, 0 (not 13).
- **Priority:** hold `led_in[2]`=1 across several `tick` cycles → level stays at `max_level`. Change `max_level` 15→3 while held → level=3 on the next cycle.
- **Chaser pattern:** feed a walking one (one channel per 8 cycles) → up to 3–4 trailing channels lit at levels decreasing by 5 per tick behind the head; every channel eventually reaches 0.
